// File: rtl/inv_cipher.sv
// inv_cipher: iterative AES InvCipher (FIPS-197), one round per clock, start/busy/done handshake.
// Define INV_CIPHER_KEY_LATCH_EN to capture the key schedule at accept so word may change while busy.
module inv_cipher #(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [127:0]          in,
  input  logic [128*(Nr+1)-1:0] word,
  output logic [127:0]          out,
  output logic                  busy,
  output logic                  done
);
  localparam logic [2047:0] inv_sbox = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
  typedef enum logic [1:0] {IDLE, ROUND, LAST} state_e;
  state_e                fsm_q;
  logic [127:0]          state_q, out_q, ark_d, round_d, rk;
  logic [3:0]            cnt_q;
  logic                  busy_q, done_q;
  logic [128*(Nr+1)-1:0] key;
  if (N != 32*Nk || Nr != Nk + 6) begin : g_bad_cfg
    $error("inv_cipher: N, Nr and Nk disagree");
  end
  function automatic logic [7:0] isb(input logic [7:0] b);
    return inv_sbox[8*(255-int'(b)) +: 8];
  endfunction
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  // GF(2^8) multiply by a 4-bit constant, built from doublings
  function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] b2, b4, b8;
    b2 = xt(b);
    b4 = xt(b2);
    b8 = xt(b4);
    return (c[3] ? b8 : 8'h00) ^ (c[2] ? b4 : 8'h00) ^ (c[1] ? b2 : 8'h00) ^ (c[0] ? b : 8'h00);
  endfunction
  function automatic logic [31:0] imc(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
            gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
            gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
            gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)};
  endfunction
`ifdef INV_CIPHER_KEY_LATCH_EN
  logic [128*(Nr+1)-1:0] key_q;
  assign key = key_q;
`else
  assign key = word;
`endif
  // cnt_q reaches 0 on entry to LAST, so the same select yields rk[0] for the final round
  assign rk = key[128*(Nr-int'(cnt_q)) +: 128];
  always_comb begin
    ark_d = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        ark_d[127-8*(r+4*c) -: 8] = isb(state_q[127-8*(r+4*((c+4-r)%4)) -: 8]) ^ rk[127-8*(r+4*c) -: 8];
  end
  assign round_d = {imc(ark_d[127:96]), imc(ark_d[95:64]), imc(ark_d[63:32]), imc(ark_d[31:0])};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef INV_CIPHER_KEY_LATCH_EN
      key_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        IDLE: if (start) begin
          state_q <= in ^ word[127:0];
          cnt_q   <= 4'(Nr - 1);
          busy_q  <= 1'b1;
          fsm_q   <= (Nr == 1) ? LAST : ROUND;
`ifdef INV_CIPHER_KEY_LATCH_EN
          key_q   <= word;
`endif
        end
        ROUND: begin
          state_q <= round_d;
          cnt_q   <= cnt_q - 4'd1;
          fsm_q   <= (cnt_q == 4'd1) ? LAST : ROUND;
        end
        LAST: begin
          out_q  <= ark_d;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          fsm_q  <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end
  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_inv_cipher.sv
// tb_inv_cipher: scoreboard bench for inv_cipher at Nr=10/12/14 using FIPS-197 vectors.
module tb_inv_cipher;
  typedef struct { logic [127:0] pt; bit eq; int gap; } exp_t;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_C4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_C8 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a [3];
  logic [127:0] in_a [3];
  logic [127:0] out_a [3];
  logic busy_a [3];
  logic done_a [3];
  logic [1407:0] w10;
  logic [1663:0] w12;
  logic [1919:0] w14;
  logic [1919:0] ks_b, ks_c4, ks_c6, ks_c8;
  logic [7:0] sbox [256];
  exp_t q [3][$];
  exp_t me;
  int total = 0, passed = 0, t = 0;
  int bc [3], last [3];
  bit latch_eq;

  always #5 clk = ~clk;

  inv_cipher #(.N(128), .Nr(10), .Nk(4)) u10 (.clk(clk), .rst(rst), .start(start_a[0]), .in(in_a[0]),
    .word(w10), .out(out_a[0]), .busy(busy_a[0]), .done(done_a[0]));
  inv_cipher #(.N(192), .Nr(12), .Nk(6)) u12 (.clk(clk), .rst(rst), .start(start_a[1]), .in(in_a[1]),
    .word(w12), .out(out_a[1]), .busy(busy_a[1]), .done(done_a[1]));
  inv_cipher #(.N(256), .Nr(14), .Nk(8)) u14 (.clk(clk), .rst(rst), .start(start_a[2]), .in(in_a[2]),
    .word(w14), .out(out_a[2]), .busy(busy_a[2]), .done(done_a[2]));

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = xt(a);
    end
    return p;
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction
  // key schedule with round key 0 in the top 128 bits, 60 words regardless of Nk
  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0] rc;
    logic [1919:0] ks;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) begin
      if (i < nk) w[i] = key[255-32*i -: 32];
      else begin
        tmp = w[i-1];
        if (i % nk == 0) begin
          tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4) tmp = subw(tmp);
        w[i] = w[i-nk] ^ tmp;
      end
      ks[1919-32*i -: 32] = w[i];
    end
    return ks;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp, input bit eq);
    total++;
    if (eq ? (act === exp) : (act !== exp)) passed++;
    else $display("FAIL %s: got %h, required %s%h", nm, act, eq ? "" : "a value other than ", exp);
  endtask
  task automatic chk_int(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, required %0d", nm, act, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic issue(input int k, input logic [127:0] ct, input logic [127:0] pt, input bit eq, input int gap);
    exp_t e;
    e.pt = pt;
    e.eq = eq;
    e.gap = gap;
    q[k].push_back(e);
    in_a[k] = ct;
    start_a[k] = 1'b1;
    tick(1);
    start_a[k] = 1'b0;
  endtask
  task automatic wait_done(input int k);
    int n = 0;
    while (!done_a[k] && n < 40) begin tick(1); n++; end
    if (n == 40) begin total++; $display("FAIL nr%0d done timeout: no done after %0d cycles, required done", 10+2*k, n); end
  endtask
  task automatic wait_idle(input int k);
    int n = 0;
    while ((q[k].size() != 0 || busy_a[k]) && n < 60) begin tick(1); n++; end
    if (n == 60) begin total++; $display("FAIL nr%0d completion timeout: busy after %0d cycles, required idle", 10+2*k, n); end
  endtask

  // monitor: pops the scoreboard on every done and checks result, busy length and pulse spacing
  initial forever begin
    @(negedge clk);
    t++;
    for (int k = 0; k < 3; k++) begin
      if (rst) bc[k] = 0;
      else if (done_a[k]) begin
        if (q[k].size() == 0) begin
          total++;
          $display("FAIL nr%0d unexpected done: out=%h, required no done pulse", 10+2*k, out_a[k]);
        end else begin
          me = q[k].pop_front();
          chk($sformatf("nr%0d out", 10+2*k), out_a[k], me.pt, me.eq);
          chk_int($sformatf("nr%0d busy cycles", 10+2*k), bc[k], 10+2*k);
          if (me.gap != 0) chk_int($sformatf("nr%0d done spacing", 10+2*k), t - last[k], me.gap);
        end
        last[k] = t;
        bc[k] = 0;
      end else if (busy_a[k]) bc[k]++;
    end
  end

  initial begin
`ifdef INV_CIPHER_KEY_LATCH_EN
    latch_eq = 1'b1;
`else
    latch_eq = 1'b0;
`endif
    for (int k = 0; k < 3; k++) begin start_a[k] = 1'b0; in_a[k] = '0; bc[k] = 0; last[k] = 0; end
    w10 = '0; w12 = '0; w14 = '0;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] v;
      v = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      sbox[x] = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    end
    ks_b  = expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
    ks_c4 = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    ks_c6 = expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
    ks_c8 = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
    tick(2);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("nr%0d reset out", 10+2*k), out_a[k], '0, 1'b1);
      chk_int($sformatf("nr%0d reset busy", 10+2*k), int'(busy_a[k]), 0);
      chk_int($sformatf("nr%0d reset done", 10+2*k), int'(done_a[k]), 0);
    end
    rst = 1'b0;
    tick(1);
    w10 = ks_b[1919 -: 1408];
    issue(0, CT_B, PT_B, 1'b1, 0);
    wait_idle(0);
    w10 = ks_c4[1919 -: 1408];
    w12 = ks_c6[1919 -: 1664];
    w14 = ks_c8;
    issue(0, CT_C4, PT_C, 1'b1, 0);
    issue(1, CT_C6, PT_C, 1'b1, 0);
    issue(2, CT_C8, PT_C, 1'b1, 0);
    for (int k = 0; k < 3; k++) wait_idle(k);
    // start held high: second block accepted right after the first done
    w10 = ks_b[1919 -: 1408];
    me.pt = PT_B; me.eq = 1'b1; me.gap = 0;
    q[0].push_back(me);
    me.gap = 11;
    q[0].push_back(me);
    in_a[0] = CT_B;
    start_a[0] = 1'b1;
    tick(3);
    in_a[0] = 128'hdeadbeef_0badf00d_cafebabe_01234567;
    tick(5);
    in_a[0] = CT_B;
    wait_done(0);
    tick(1);
    start_a[0] = 1'b0;
    wait_idle(0);
    // back-to-back with a key change in the done cycle
    issue(0, CT_B, PT_B, 1'b1, 0);
    wait_done(0);
    w10 = ks_c4[1919 -: 1408];
    issue(0, CT_C4, PT_C, 1'b1, 11);
    wait_idle(0);
    // asynchronous reset mid-block
    w10 = ks_b[1919 -: 1408];
    issue(0, CT_B, PT_B, 1'b1, 0);
    tick(4);
    #2 rst = 1'b1;
    #1;
    chk("abort out", out_a[0], '0, 1'b1);
    chk_int("abort busy", int'(busy_a[0]), 0);
    chk_int("abort done", int'(done_a[0]), 0);
    q[0].delete();
    tick(2);
    rst = 1'b0;
    tick(15);
    issue(0, CT_B, PT_B, 1'b1, 0);
    wait_idle(0);
    // key schedule cleared right after accept
    issue(0, CT_B, PT_B, latch_eq, 0);
    w10 = '0;
    wait_idle(0);
    for (int k = 0; k < 3; k++) chk_int($sformatf("nr%0d scoreboard drained", 10+2*k), q[k].size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/inv_cipher.md
Name: inv_cipher

Overview:
- Iterative AES decryption core (FIPS-197 InvCipher); one round per clock.
- Consumes the same packed key-schedule bus the encryption core uses. The pair forms the encrypt/decrypt datapath.
- Adds an explicit start/busy/done handshake and an asynchronous reset.
- Sits after the key expansion block; its output feeds the block-mode / output register logic.

Parameters:
- N, 128, key length in bits (128/192/256); informational, must agree with Nr/Nk.
- Nr, 10, number of rounds (10/12/14).
- Nk, 4, key length in 32-bit words (4/6/8).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request to decrypt `in`; sampled only when busy=0.
- in  input  128  ciphertext block; bit 127 = MSB of byte 0, column-major per FIPS-197.
- word  input  128*(Nr+1)  expanded key schedule.
  - Round key r at word[128*(Nr+1)-1-128*r -: 128].
  - Round key 0 is the top slice; round key Nr is word[127:0].
- out  output  128  plaintext; holds last result until the next done.
- busy  output  1  high while a block is in progress.
- done  output  1  one-cycle pulse when out is updated.

Behaviour:
- Reset (async, rst=1):
  - out=0, busy=0, done=0.
  - Internal state=0, round counter=0, FSM=IDLE.
  - Reset mid-operation aborts the block with no done pulse.
- Round key rk[r] is indexed from word as in Ports; rk[Nr] is applied first.
- FSM states: IDLE, ROUND, LAST.
- IDLE:
  - start=1 at an edge: state <= in ^ rk[Nr]; cnt <= Nr-1; busy <= 1.
  - Go to ROUND, or to LAST if Nr-1 = 0 (not a legal config, but not guarded).
- ROUND, each edge:
  - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[cnt]); cnt <= cnt-1.
  - When cnt=1, go to LAST.
- LAST, one edge:
  - out <= InvSubBytes(InvShiftRows(state)) ^ rk[0]; done <= 1; busy <= 0; go to IDLE.
- done is high for exactly one cycle, the cycle after the LAST edge. It deasserts on the next edge unless a new block completes there (impossible by latency).
- Latency: done is high Nr cycles after the edge that accepted start (10/12/14). A new start may be issued in the cycle done is high, giving throughput of one block per Nr+1 cycles.
- start while busy=1 is ignored; no queueing and no error.
- in is sampled only at the accept edge and may change afterward.
- word must be held stable while busy=1 (see Optional Feature).
- Inverse transforms are combinational sub-blocks:
  - InvShiftRows: row r rotated right by r.
  - InvSubBytes: inverse S-box.
  - InvMixColumns: GF(2^8) multiply by {0e,0b,0d,09}, reduction polynomial 0x11b.
- No X-checking in the datapath; X on inputs propagates, and the FSM never gates on X.

Optional Feature:
- Macro: INV_CIPHER_KEY_LATCH_EN.
- Defined:
  - An internal 128*(Nr+1) register captures word at the accept edge, and all rounds use the captured copy.
  - word may change freely while busy=1.
  - The register resets to 0.
- Undefined:
  - No key register; rounds read word live.
  - Changing word while busy=1 corrupts the result, but the handshake timing is unchanged.

Test Plan:
- AES-128, FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c expanded, in=3925841d02dc09fbdc118597196a0b32, start pulse -> done 10 cycles later, out=3243f6a8885a308d313198a2e0370734, busy high for exactly those 10 cycles.
- Parameter sweep, FIPS-197 App. C, key 000102…(Nk*4 bytes), expected out=00112233445566778899aabbccddeeff:
  - Nr=10/Nk=4: in=69c4e0d86a7b0430d8cdb78070b4c55a, done after 10 cycles.
  - Nr=12/Nk=6: in=dda97ca4864cdfe06eaf70a0ec0d7191, done after 12 cycles.
  - Nr=14/Nk=8: in=8ea2b7ca516745bfeafc49904b496089, done after 14 cycles.
- start held high through the whole operation with in changed at cycle 3 -> single result equal to decrypt of the in sampled at accept. The next block is accepted in the done cycle and its done follows 10 cycles later.
- rst asserted asynchronously mid-block (cycle 5) -> out=0, busy=0 immediately with no done. The same App. B vector restarted after reset -> correct result.
- Back-to-back: App. B then App. C-128 vectors with start issued in each done cycle -> two correct results, done pulses 11 cycles apart.
- With INV_CIPHER_KEY_LATCH_EN, word zeroed one cycle after accept -> out still 3243f6a8…0734. Without the macro -> out differs, and done timing is unchanged.
